// File: rtl/framebuffer_write_port_if.sv
// Output stream of the framebuffer write port: queue head and its accept handshake.
interface framebuffer_write_port_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        out_data;

  modport master (output out_valid, output out_addr, output out_data, input out_ready);
  modport slave  (input out_valid, input out_addr, input out_data, output out_ready);
endinterface

// File: rtl/framebuffer_write_port.sv
// Framebuffer write port: toggle-signalled byte write requests are range-checked,
// linearised to a byte address and queued for the framebuffer.
package params;
  localparam int unsigned BYTES_PER_PIXEL = 2;
  localparam int unsigned PIXEL_WIDTH     = 64;
  localparam int unsigned PIXEL_HEIGHT    = 32;
endpackage

package types;
  localparam int unsigned ROW_W = 16;
  localparam int unsigned COL_W = 16;
  typedef logic [ROW_W-1:0] row_addr_t;
  typedef logic [COL_W-1:0] col_addr_t;
endpackage

package calc;
  // At least one select bit so single-byte pixels still have a legal port.
  function automatic int unsigned num_pixelcolorselect_bits(input int unsigned bpp);
    return (bpp <= 1) ? 1 : $clog2(bpp);
  endfunction
endpackage

module framebuffer_write_port #(
  parameter int unsigned  BYTES_PER_PIXEL = params::BYTES_PER_PIXEL,
  parameter int unsigned  PIXEL_WIDTH     = params::PIXEL_WIDTH,
  parameter int unsigned  PIXEL_HEIGHT    = params::PIXEL_HEIGHT,
  parameter int unsigned  FIFO_DEPTH      = 4,
  localparam int unsigned ADDR_W = $clog2(PIXEL_HEIGHT * PIXEL_WIDTH * BYTES_PER_PIXEL),
  localparam int unsigned PSEL_W = calc::num_pixelcolorselect_bits(BYTES_PER_PIXEL)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  types::row_addr_t         row,
  input  types::col_addr_t         column,
  input  logic [PSEL_W-1:0]        pixel,
  input  logic [7:0]               data_in,
  input  logic                     ram_write_enable,
  input  logic                     ram_access_start,
  input  logic                     clear_errors,
  framebuffer_write_port_if.master fb,
  output logic                     overflow,
  output logic                     range_error,
  output logic [15:0]              write_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              tog_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [7:0]        data_mem [FIFO_DEPTH];

  logic              req_c;
  logic              in_range_c;
  logic              full_c;
  logic              pop_c;
  logic              push_c;
  logic              ovf_set_c;
  logic              rng_set_c;
  logic [ADDR_W-1:0] addr_c;

  // Request decode, address linearisation and queue control.
  always_comb begin
    req_c      = (ram_access_start != tog_q) && ram_write_enable;
    in_range_c = (32'(row) < PIXEL_HEIGHT) && (32'(column) < PIXEL_WIDTH) &&
                 (32'(pixel) < BYTES_PER_PIXEL);
    addr_c     = ADDR_W'((32'(row) * PIXEL_WIDTH + 32'(column)) * BYTES_PER_PIXEL +
                         32'(pixel));
    full_c     = (count == CNT_W'(FIFO_DEPTH));
    pop_c      = (count != '0) && fb.out_ready;
    // A pop frees a slot on the same edge, so a full queue may still accept.
    push_c     = req_c && in_range_c && (!full_c || pop_c);
    ovf_set_c  = req_c && in_range_c && full_c && !pop_c;
    rng_set_c  = req_c && !in_range_c;
  end

  assign fb.out_valid = (count != '0);
  assign fb.out_addr  = addr_mem[rd_ptr];
  assign fb.out_data  = data_mem[rd_ptr];

  // Queue storage carries no reset; it is only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (push_c) begin
      addr_mem[wr_ptr] <= addr_c;
      data_mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tog_q       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      range_error <= 1'b0;
      write_count <= '0;
    end else begin
      tog_q <= ram_access_start;
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        write_count <= write_count + 16'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A new error in the same cycle as a clear leaves the flag set.
      overflow    <= ovf_set_c | (overflow & ~clear_errors);
      range_error <= rng_set_c | (range_error & ~clear_errors);
    end
  end

endmodule
